frame_sequencer: RTL and testbench

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/afinador_pkg.sv | 33 +++
 rtl/frame_sequencer_peak_finder.sv | 40 ++++
 rtl/frame_sequencer.sv | 162 ++++++++++++++++
 tb/tb_frame_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/afinador_pkg.sv
// Shared types and defaults for the frame sequencer: FSM state encoding,
// parameter defaults and the bit-reversal helper used for FFT input ordering.
package afinador_pkg;

  localparam int N_LOG2_DEF = 10;
  localparam int DATA_W_DEF = 10;
  localparam int ADDR_W_DEF = 11;
  localparam int MAG_W_DEF  = 16;
  localparam int REV_MAX_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_START,
    ST_WAIT,
    ST_SCAN,
    ST_REPORT
  } state_t;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [REV_MAX_W-1:0] bit_rev(input logic [REV_MAX_W-1:0] v,
                                                   input int w);
    logic [REV_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < REV_MAX_W; i++) begin
      for (int j = 0; j < REV_MAX_W; j++) begin
        if ((i < w) && (i + j == w - 1)) r[i] = v[j];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/frame_sequencer_peak_finder.sv
// Running-maximum tracker over a stream of (bin, magnitude) pairs.
// The first pair after a clear is taken unconditionally; later ones replace it only if strictly larger.
module peak_finder import afinador_pkg::*; #(
  parameter int BIN_W = N_LOG2_DEF - 1,
  parameter int MAG_W = MAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_valid,
  input  logic [BIN_W-1:0] i_bin,
  input  logic [MAG_W-1:0] i_mag,
  output logic [BIN_W-1:0] o_bin,
  output logic [MAG_W-1:0] o_mag
);

  logic             r_first;
  logic [BIN_W-1:0] r_bin;
  logic [MAG_W-1:0] r_mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first <= 1'b1;
      r_bin   <= '0;
      r_mag   <= '0;
    end else if (i_clear) begin
      r_first <= 1'b1;
      r_bin   <= '0;
      r_mag   <= '0;
    end else if (i_valid && (r_first || (i_mag > r_mag))) begin
      r_first <= 1'b0;
      r_bin   <= i_bin;
      r_mag   <= i_mag;
    end
  end

  assign o_bin = r_bin;
  assign o_mag = r_mag;

endmodule

// File: rtl/frame_sequencer.sv
// Captures one frame of ADC samples in bit-reversed order, kicks the FFT core,
// then scans the non-DC half-spectrum for its strongest bin and reports it.
module frame_sequencer import afinador_pkg::*; #(
  parameter int N_LOG2 = N_LOG2_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int MAG_W  = MAG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              fft_start,
  input  logic              fft_done,
  output logic [N_LOG2-2:0] mag_addr,
  input  logic [MAG_W-1:0]  mag_rdata,
  output logic [N_LOG2-2:0] peak_bin,
  output logic [MAG_W-1:0]  peak_mag,
  output logic              peak_valid,
  output logic              busy,
  output logic              overrun,
  output state_t            dbg_state
);

  localparam int BIN_W = N_LOG2 - 1;

  state_t            r_state;
  logic [N_LOG2-1:0] r_cnt;
  logic [BIN_W-1:0]  r_scan_cnt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_we;
  logic              r_fft_start;
  logic [BIN_W-1:0]  r_mag_addr;
  logic [BIN_W-1:0]  r_peak_bin;
  logic [MAG_W-1:0]  r_peak_mag;
  logic              r_peak_valid;
  logic              r_overrun;

  logic [N_LOG2-1:0] w_rev;
  logic              w_pf_clear;
  logic              w_pf_valid;
  logic [BIN_W-1:0]  w_pf_bin;
  logic [MAG_W-1:0]  w_pf_mag;

  assign w_rev = N_LOG2'(bit_rev(REV_MAX_W'(r_cnt), N_LOG2));

  // Read data for the address issued in SCAN cycle k-1 arrives in cycle k, so
  // cycle k carries bin k; cycle 0 has no data (DC bin is never read).
  assign w_pf_clear = (r_state == ST_WAIT) && fft_done;
  assign w_pf_valid = (r_state == ST_SCAN) && (r_scan_cnt != '0);

  peak_finder #(
    .BIN_W (BIN_W),
    .MAG_W (MAG_W)
  ) u_peak_finder (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_pf_clear),
    .i_valid (w_pf_valid),
    .i_bin   (r_scan_cnt),
    .i_mag   (mag_rdata),
    .o_bin   (w_pf_bin),
    .o_mag   (w_pf_mag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_scan_cnt   <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_we     <= 1'b0;
      r_fft_start  <= 1'b0;
      r_mag_addr   <= '0;
      r_peak_bin   <= '0;
      r_peak_mag   <= '0;
      r_peak_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_mem_we     <= 1'b0;
      r_fft_start  <= 1'b0;
      r_peak_valid <= 1'b0;
      if (sample_valid &&
          (r_state inside {ST_START, ST_WAIT, ST_SCAN, ST_REPORT})) begin
        r_overrun <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_state   <= ST_CAPTURE;
            r_cnt     <= '0;
            r_overrun <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (!enable) begin
            r_state <= ST_IDLE;
          end else if (sample_valid) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= ADDR_W'(w_rev);
            r_mem_wdata <= sample_in;
            r_cnt       <= r_cnt + 1'b1;
            if (r_cnt == '1) begin
              // fft_start is raised on entry so it is high exactly while in START.
              r_state     <= ST_START;
              r_fft_start <= 1'b1;
            end
          end
        end
        ST_START: begin
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (fft_done) begin
            r_state    <= ST_SCAN;
            r_scan_cnt <= '0;
            r_mag_addr <= BIN_W'(1);
          end
        end
        ST_SCAN: begin
          r_scan_cnt <= r_scan_cnt + 1'b1;
          if (r_mag_addr != '1) r_mag_addr <= r_mag_addr + 1'b1;
          if (r_scan_cnt == '1) begin
            r_state    <= ST_REPORT;
            r_mag_addr <= '0;
          end
        end
        ST_REPORT: begin
          r_peak_bin   <= w_pf_bin;
          r_peak_mag   <= w_pf_mag;
          r_peak_valid <= 1'b1;
          if (enable) begin
            r_state <= ST_CAPTURE;
            r_cnt   <= '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_we     = r_mem_we;
  assign fft_start  = r_fft_start;
  assign mag_addr   = r_mag_addr;
  assign peak_bin   = r_peak_bin;
  assign peak_mag   = r_peak_mag;
  assign peak_valid = r_peak_valid;
  assign overrun    = r_overrun;
  assign busy       = (r_state != ST_IDLE);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: randomized frames and magnitude spectra checked
// against a queue of expected RAM writes and an argmax model of the spectrum.
module tb_frame_sequencer;
  import afinador_pkg::*;

  localparam int N_LOG2   = 10;
  localparam int DATA_W   = 10;
  localparam int ADDR_W   = 11;
  localparam int MAG_W    = 16;
  localparam int N        = 1 << N_LOG2;
  localparam int HALF     = N / 2;
  localparam int SCAN_LAT = HALF + 2;  // SCAN length, one REPORT cycle, registered pulse
  localparam int EW       = 20 + ADDR_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [DATA_W-1:0] sample_in = '0;
  logic              sample_valid = 1'b0;
  logic              fft_done = 1'b0;
  logic [MAG_W-1:0]  mag_rdata = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              fft_start;
  logic [N_LOG2-2:0] mag_addr;
  logic [N_LOG2-2:0] peak_bin;
  logic [MAG_W-1:0]  peak_mag;
  logic              peak_valid;
  logic              busy;
  logic              overrun;
  state_t            dbg_state;

  logic [MAG_W-1:0]  mag_ram [HALF];
  logic [DATA_W-1:0] ram_seen [1 << ADDR_W];
  logic [EW-1:0]     exp_q [$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int pv_cnt = 0;
  int fidx = 0;

  frame_sequencer #(
    .N_LOG2 (N_LOG2),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .MAG_W  (MAG_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .fft_start    (fft_start),
    .fft_done     (fft_done),
    .mag_addr     (mag_addr),
    .mag_rdata    (mag_rdata),
    .peak_bin     (peak_bin),
    .peak_mag     (peak_mag),
    .peak_valid   (peak_valid),
    .busy         (busy),
    .overrun      (overrun),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset / memories ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) mag_rdata <= mag_ram[mag_addr];

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: every RAM write must match the oldest expected entry, in the right cycle.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (fft_start) start_cnt++;
    if (peak_valid) pv_cnt++;
    if (mem_we) begin
      ram_seen[mem_addr] = mem_wdata;
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'(mem_we), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("write_cycle", 32'(cyc), 32'(e[EW-1 -: 20]));
        chk("write_addr", 32'(mem_addr), 32'(e[DATA_W +: ADDR_W]));
        chk("write_data", 32'(mem_wdata), 32'(e[DATA_W-1:0]));
      end
    end
  end

  // Peak model: largest magnitude over bins 1..HALF-1, lowest bin on ties.
  function automatic int ref_peak_bin();
    int m;
    m = 0;
    for (int b = 1; b < HALF; b++) if (int'(mag_ram[b]) > m) m = int'(mag_ram[b]);
    for (int b = 1; b < HALF; b++) if (int'(mag_ram[b]) == m) return b;
    return 1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_sample(input logic [DATA_W-1:0] v);
    logic [N_LOG2-1:0] idx;
    logic [N_LOG2-1:0] rev;
    idx = N_LOG2'(fidx);
    rev = {<<{idx}};
    sample_valid = 1'b1;
    sample_in    = v;
    exp_q.push_back({20'(cyc + 1), ADDR_W'(rev), v});
    fidx++;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic begin_capture();
    enable = 1'b1;
    fidx   = 0;
    tick(1);
  endtask

  task automatic feed(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      push_sample(rnd ? DATA_W'($urandom) : DATA_W'(i));
      if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 2));
    end
  endtask

  task automatic fill_mag(input int lo_max);
    for (int b = 0; b < HALF; b++) mag_ram[b] = MAG_W'($urandom_range(0, lo_max));
  endtask

  task automatic pulse_drop(input int n);
    for (int i = 0; i < n; i++) begin
      sample_valid = 1'b1;
      sample_in    = DATA_W'($urandom);
      tick(1);
      sample_valid = 1'b0;
      tick(1);
    end
  endtask

  task automatic run_scan(input int extra_done_at);
    int t0;
    int exp_bin;
    int k;
    exp_bin  = ref_peak_bin();
    fft_done = 1'b1;
    t0       = cyc;
    tick(1);
    fft_done = 1'b0;
    for (k = 0; k < 2 * SCAN_LAT && !peak_valid; k++) begin
      fft_done = (k == extra_done_at);
      tick(1);
    end
    fft_done = 1'b0;
    chk("peak_seen", 32'(peak_valid), 32'd1);
    if (peak_valid) begin
      chk("peak_latency", 32'(cyc - t0), 32'(SCAN_LAT));
      chk("peak_bin", 32'(peak_bin), 32'(exp_bin));
      chk("peak_mag", 32'(peak_mag), 32'(mag_ram[exp_bin]));
      tick(1);
      chk("peak_pulse_width", 32'(peak_valid), 32'd0);
      chk("peak_bin_hold", 32'(peak_bin), 32'(exp_bin));
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_fft_start", 32'(fft_start), 32'd0);
    chk("rst_mag_addr", 32'(mag_addr), 32'd0);
    chk("rst_peak_bin", 32'(peak_bin), 32'd0);
    chk("rst_peak_mag", 32'(peak_mag), 32'd0);
    chk("rst_peak_valid", 32'(peak_valid), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int s0;
    int p0;
    for (int b = 0; b < HALF; b++) mag_ram[b] = '0;
    tick(3);
    chk_reset_vals();
    rst_n = 1'b1;
    tick(2);

    // Samples in IDLE are dropped silently.
    pulse_drop(2);
    chk("idle_drop_overrun", 32'(overrun), 32'd0);

    // Frame A: ramp data, enable dropped in START/WAIT (ignored), single peak at bin 37.
    s0 = start_cnt;
    begin_capture();
    feed(N, 1'b0);
    enable = 1'b0;
    tick(2);
    chk("a_fft_start_count", 32'(start_cnt), 32'(s0 + 1));
    chk("a_writes_pending", 32'(exp_q.size()), 32'd0);
    chk("a_busy_wait", 32'(busy), 32'd1);
    chk("a_ram_512", 32'(ram_seen[512]), 32'd1);
    chk("a_ram_768", 32'(ram_seen[768]), 32'd3);
    fill_mag(100);
    mag_ram[37] = 16'd900;
    run_scan(-1);
    tick(2);
    chk("a_idle_after_report", 32'(busy), 32'd0);

    // Frame B: random data, drops in WAIT, tied maxima at 5 and 200, loud DC bin, stray fft_done in SCAN.
    s0 = start_cnt;
    begin_capture();
    feed(N, 1'b1);
    tick(2);
    chk("b_fft_start_count", 32'(start_cnt), 32'(s0 + 1));
    pulse_drop(3);
    chk("b_overrun_set", 32'(overrun), 32'd1);
    chk("b_writes_pending", 32'(exp_q.size()), 32'd0);
    enable = 1'b0;
    fill_mag(699);
    mag_ram[0]   = 16'd9999;
    mag_ram[5]   = 16'd700;
    mag_ram[200] = 16'd700;
    run_scan(100);
    chk("b_overrun_held", 32'(overrun), 32'd1);
    chk("b_single_start", 32'(start_cnt), 32'(s0 + 1));

    // Frame C: abort after 300 samples with a coincident sample, then full frames.
    s0 = start_cnt;
    begin_capture();
    chk("c_overrun_cleared", 32'(overrun), 32'd0);
    feed(300, 1'b1);
    enable       = 1'b0;
    sample_valid = 1'b1;
    sample_in    = DATA_W'($urandom);
    tick(1);
    sample_valid = 1'b0;
    tick(3);
    chk("c_abort_idle", 32'(busy), 32'd0);
    chk("c_abort_no_start", 32'(start_cnt), 32'(s0));
    chk("c_abort_writes", 32'(exp_q.size()), 32'd0);
    begin_capture();
    feed(N, 1'b1);
    tick(2);
    chk("c_fft_start_count", 32'(start_cnt), 32'(s0 + 1));
    fill_mag(65535);
    run_scan(-1);
    chk("c_recapture_busy", 32'(busy), 32'd1);
    fidx = 0;
    feed(N, 1'b1);
    enable = 1'b0;
    tick(2);
    chk("c_second_start", 32'(start_cnt), 32'(s0 + 2));
    chk("c2_writes_pending", 32'(exp_q.size()), 32'd0);

    // Frame D: reset in the middle of SCAN, then a late fft_done.
    pulse_drop(1);
    chk("d_overrun_set", 32'(overrun), 32'd1);
    fill_mag(65535);
    fft_done = 1'b1;
    tick(1);
    fft_done = 1'b0;
    tick(50);
    chk("d_busy_scan", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    tick(2);
    rst_n = 1'b1;
    tick(2);
    s0 = start_cnt;
    p0 = pv_cnt;
    fft_done = 1'b1;
    tick(1);
    fft_done = 1'b0;
    tick(600);
    chk("d_no_peak_after_reset", 32'(pv_cnt), 32'(p0));
    chk("d_idle_after_reset", 32'(busy), 32'd0);
    chk("d_no_start_after_reset", 32'(start_cnt), 32'(s0));
    chk("d_mag_addr_idle", 32'(mag_addr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
